// File: rtl/rom_data_arbiter_if.sv
// Bundle of the two master request/response channels and the ROM data port
// seen by rom_data_arbiter. The arbiter uses the slave view; whatever drives
// the masters and models the ROM uses the master view.
interface rom_data_arbiter_if;
   // master 0 (core load/store unit)
   logic        i_M0_REQ;
   logic [31:0] i_M0_ADDR;
   logic [1:0]  i_M0_HB;
   logic        o_M0_GNT;
   logic        o_M0_ERR;
   logic [31:0] o_M0_RDATA;
   // master 1 (debug/DMA reader)
   logic        i_M1_REQ;
   logic [31:0] i_M1_ADDR;
   logic [1:0]  i_M1_HB;
   logic        o_M1_GNT;
   logic        o_M1_ERR;
   logic [31:0] o_M1_RDATA;
   // ROM data port
   logic        o_ROM_CE;
   logic        o_ROM_REQ;
   logic [1:0]  o_ROM_HB;
   logic [31:0] o_ROM_ADDR;
   logic [31:0] i_ROM_RDATA;
   logic        i_ROM_GNT;

   modport slave (
      input  i_M0_REQ, i_M0_ADDR, i_M0_HB,
      output o_M0_GNT, o_M0_ERR, o_M0_RDATA,
      input  i_M1_REQ, i_M1_ADDR, i_M1_HB,
      output o_M1_GNT, o_M1_ERR, o_M1_RDATA,
      output o_ROM_CE, o_ROM_REQ, o_ROM_HB, o_ROM_ADDR,
      input  i_ROM_RDATA, i_ROM_GNT
   );

   modport master (
      output i_M0_REQ, i_M0_ADDR, i_M0_HB,
      input  o_M0_GNT, o_M0_ERR, o_M0_RDATA,
      output i_M1_REQ, i_M1_ADDR, i_M1_HB,
      input  o_M1_GNT, o_M1_ERR, o_M1_RDATA,
      input  o_ROM_CE, o_ROM_REQ, o_ROM_HB, o_ROM_ADDR,
      output i_ROM_RDATA, i_ROM_GNT
   );
endinterface

// File: rtl/rom_data_arbiter.sv
// Two-master arbiter for the boot ROM data read port. Alternates between
// masters when both request, forwards the ROM grant/data to the owner, and
// aborts an access with an error pulse if the ROM never grants it.
module rom_data_arbiter #(
   parameter int unsigned TIMEOUT = 15   // BUSY cycles before abort, 2..255
) (
   input  logic               i_CLK,
   input  logic               i_RST,
   rom_data_arbiter_if.slave  bus
);

   localparam int NUM_M = 2;
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   // per-master request view, indexed by master number
   logic [NUM_M-1:0]        w_req;
   logic [NUM_M-1:0][31:0]  w_req_addr;
   logic [NUM_M-1:0][1:0]   w_req_hb;
   // per-master response pulses and data
   logic [NUM_M-1:0]        w_gnt;
   logic [NUM_M-1:0]        w_err;
   logic [NUM_M-1:0][31:0]  w_rdata;

   state_t      r_state, w_state_nxt;
   logic        r_owner, w_owner_nxt;
   logic        r_last,  w_last_nxt;
   logic [31:0] r_addr,  w_addr_nxt;
   logic [1:0]  r_hb,    w_hb_nxt;
   logic [7:0]  r_tmo,   w_tmo_nxt;

   logic        w_pick;
   logic        w_other;

   assign w_req      = {bus.i_M1_REQ,  bus.i_M0_REQ};
   assign w_req_addr = {bus.i_M1_ADDR, bus.i_M0_ADDR};
   assign w_req_hb   = {bus.i_M1_HB,   bus.i_M0_HB};

   // Single requester wins outright; on a tie the master not served last wins.
   assign w_pick  = (w_req == 2'b11) ? ~r_last : ~w_req[0];
   assign w_other = ~r_owner;

   // State, ownership, latched access and watchdog registers.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         r_state <= S_IDLE;
         r_owner <= 1'b0;
         r_last  <= 1'b1;
         r_addr  <= '0;
         r_hb    <= '0;
         r_tmo   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
         r_last  <= w_last_nxt;
         r_addr  <= w_addr_nxt;
         r_hb    <= w_hb_nxt;
         r_tmo   <= w_tmo_nxt;
      end
   end

   // Next-state and response pulses. A grant in the same cycle as the
   // watchdog expiry completes the access normally. On a grant the owner's
   // own REQ is ignored so the other master gets a back-to-back turn, while
   // a repeat by the same master always passes through IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_last_nxt  = r_last;
      w_addr_nxt  = r_addr;
      w_hb_nxt    = r_hb;
      w_tmo_nxt   = r_tmo;
      w_gnt       = '0;
      w_err       = '0;
      case (r_state)
         S_IDLE: begin
            if (|w_req) begin
               w_state_nxt = S_BUSY;
               w_owner_nxt = w_pick;
               w_addr_nxt  = w_req_addr[w_pick];
               w_hb_nxt    = w_req_hb[w_pick];
               w_tmo_nxt   = '0;
            end
         end
         S_BUSY: begin
            if (bus.i_ROM_GNT) begin
               w_gnt[r_owner] = 1'b1;
               w_last_nxt     = r_owner;
               if (w_req[w_other]) begin
                  w_owner_nxt = w_other;
                  w_addr_nxt  = w_req_addr[w_other];
                  w_hb_nxt    = w_req_hb[w_other];
                  w_tmo_nxt   = '0;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else if (r_tmo == TMO_LAST) begin
               w_err[r_owner] = 1'b1;
               w_last_nxt     = r_owner;
               w_state_nxt    = S_IDLE;
            end else begin
               w_tmo_nxt = r_tmo + 8'd1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Read data reaches only the master being granted; everyone else sees 0.
   for (genvar g = 0; g < NUM_M; g++) begin : g_rdata
      assign w_rdata[g] = w_gnt[g] ? bus.i_ROM_RDATA : 32'h0;
   end

   assign bus.o_M0_GNT   = w_gnt[0];
   assign bus.o_M0_ERR   = w_err[0];
   assign bus.o_M0_RDATA = w_rdata[0];
   assign bus.o_M1_GNT   = w_gnt[1];
   assign bus.o_M1_ERR   = w_err[1];
   assign bus.o_M1_RDATA = w_rdata[1];

   assign bus.o_ROM_CE   = (r_state == S_BUSY);
   assign bus.o_ROM_REQ  = (r_state == S_BUSY);
   assign bus.o_ROM_ADDR = r_addr;
   assign bus.o_ROM_HB   = r_hb;

endmodule

// File: tb/tb_rom_data_arbiter.sv
// Cycle-level directed bench for rom_data_arbiter (TIMEOUT=4). The ROM side
// is driven straight from the vector table so grant timing is explicit.
module tb_rom_data_arbiter;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   rom_data_arbiter_if bus();

   rom_data_arbiter #(.TIMEOUT(4)) u_dut (
      .i_CLK (clk),
      .i_RST (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        r0;  logic [31:0] a0; logic [1:0] h0;
      logic        r1;  logic [31:0] a1; logic [1:0] h1;
      logic        rg;  logic [31:0] rd;
      logic        ce;  logic [31:0] ra; logic [1:0] rh;
      logic        g0;  logic        e0; logic [31:0] d0;
      logic        g1;  logic        e1; logic [31:0] d1;
   } vec_t;

   localparam int NV = 39;
   vec_t tv [NV];

   function automatic vec_t v(
      input logic rst_i,
      input logic r0, input logic [31:0] a0, input logic [1:0] h0,
      input logic r1, input logic [31:0] a1, input logic [1:0] h1,
      input logic rg, input logic [31:0] rd,
      input logic ce, input logic [31:0] ra, input logic [1:0] rh,
      input logic g0, input logic e0, input logic [31:0] d0,
      input logic g1, input logic e1, input logic [31:0] d1);
      vec_t t;
      t.rst = rst_i;
      t.r0 = r0; t.a0 = a0; t.h0 = h0;
      t.r1 = r1; t.a1 = a1; t.h1 = h1;
      t.rg = rg; t.rd = rd;
      t.ce = ce; t.ra = ra; t.rh = rh;
      t.g0 = g0; t.e0 = e0; t.d0 = d0;
      t.g1 = g1; t.e1 = e1; t.d1 = d1;
      return t;
   endfunction

   task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d got %h want %h", name, row, act, exp);
      end
   endtask

   task automatic chk_all(input int row, input vec_t t);
      chk("rom_ce",   row, 32'(bus.o_ROM_CE),   32'(t.ce));
      chk("rom_req",  row, 32'(bus.o_ROM_REQ),  32'(t.ce));
      chk("rom_addr", row, bus.o_ROM_ADDR,      t.ra);
      chk("rom_hb",   row, 32'(bus.o_ROM_HB),   32'(t.rh));
      chk("m0_gnt",   row, 32'(bus.o_M0_GNT),   32'(t.g0));
      chk("m0_err",   row, 32'(bus.o_M0_ERR),   32'(t.e0));
      chk("m0_rdata", row, bus.o_M0_RDATA,      t.d0);
      chk("m1_gnt",   row, 32'(bus.o_M1_GNT),   32'(t.g1));
      chk("m1_err",   row, 32'(bus.o_M1_ERR),   32'(t.e1));
      chk("m1_rdata", row, bus.o_M1_RDATA,      t.d1);
   endtask

   task automatic drive(input vec_t t);
      rst             = t.rst;
      bus.i_M0_REQ    = t.r0; bus.i_M0_ADDR = t.a0; bus.i_M0_HB = t.h0;
      bus.i_M1_REQ    = t.r1; bus.i_M1_ADDR = t.a1; bus.i_M1_HB = t.h1;
      bus.i_ROM_GNT   = t.rg; bus.i_ROM_RDATA = t.rd;
   endtask

   initial begin
      vec_t z;
      checks = 0;
      errors = 0;

      // rst r0 a0 h0  r1 a1 h1  rg rd  ce ra rh  g0 e0 d0  g1 e1 d1
      // single M0 word access
      tv[0]  = v(0, 0,0,0,        0,0,0,        0,0,            0,0,0,        0,0,0,            0,0,0);
      tv[1]  = v(0, 0,0,0,        0,0,0,        0,0,            0,0,0,        0,0,0,            0,0,0);
      tv[2]  = v(0, 1,'h10,2,     0,0,0,        0,0,            0,0,0,        0,0,0,            0,0,0);
      tv[3]  = v(0, 1,'h10,2,     0,0,0,        0,0,            1,'h10,2,     0,0,0,            0,0,0);
      tv[4]  = v(0, 1,'h10,2,     0,0,0,        1,'hDEADBEEF,   1,'h10,2,     1,0,'hDEADBEEF,   0,0,0);
      tv[5]  = v(0, 0,0,0,        0,0,0,        0,0,            0,'h10,2,     0,0,0,            0,0,0);
      // reset, then both request together: M0 first, then alternation
      tv[6]  = v(1, 0,0,0,        0,0,0,        0,0,            0,0,0,        0,0,0,            0,0,0);
      tv[7]  = v(0, 1,'h20,1,     1,'h40,0,     0,0,            0,0,0,        0,0,0,            0,0,0);
      tv[8]  = v(0, 1,'h20,1,     1,'h40,0,     0,0,            1,'h20,1,     0,0,0,            0,0,0);
      tv[9]  = v(0, 1,'h20,1,     1,'h40,0,     1,'h11111111,   1,'h20,1,     1,0,'h11111111,   0,0,0);
      tv[10] = v(0, 1,'h20,1,     1,'h40,0,     0,0,            1,'h40,0,     0,0,0,            0,0,0);
      tv[11] = v(0, 1,'h20,1,     1,'h40,0,     1,'h22222222,   1,'h40,0,     0,0,0,            1,0,'h22222222);
      tv[12] = v(0, 1,'h20,1,     1,'h40,0,     0,0,            1,'h20,1,     0,0,0,            0,0,0);
      tv[13] = v(0, 1,'h20,1,     1,'h40,0,     1,'h33333333,   1,'h20,1,     1,0,'h33333333,   0,0,0);
      tv[14] = v(0, 1,'h20,1,     1,'h40,0,     0,0,            1,'h40,0,     0,0,0,            0,0,0);
      tv[15] = v(0, 1,'h20,1,     1,'h40,0,     1,'h44444444,   1,'h40,0,     0,0,0,            1,0,'h44444444);
      // M1 leaves; M0 keeps requesting: one access every 3 cycles
      tv[16] = v(0, 1,'h20,1,     0,0,0,        0,0,            1,'h20,1,     0,0,0,            0,0,0);
      tv[17] = v(0, 1,'h20,1,     0,0,0,        1,'h55555555,   1,'h20,1,     1,0,'h55555555,   0,0,0);
      tv[18] = v(0, 1,'h20,1,     0,0,0,        0,0,            0,'h20,1,     0,0,0,            0,0,0);
      tv[19] = v(0, 1,'h20,1,     0,0,0,        0,0,            1,'h20,1,     0,0,0,            0,0,0);
      tv[20] = v(0, 1,'h20,1,     0,0,0,        1,'h66666666,   1,'h20,1,     1,0,'h66666666,   0,0,0);
      tv[21] = v(0, 1,'h20,1,     0,0,0,        0,0,            0,'h20,1,     0,0,0,            0,0,0);
      tv[22] = v(0, 1,'h20,1,     0,0,0,        0,0,            1,'h20,1,     0,0,0,            0,0,0);
      tv[23] = v(0, 1,'h20,1,     0,0,0,        1,'h77777777,   1,'h20,1,     1,0,'h77777777,   0,0,0);
      tv[24] = v(0, 0,0,0,        0,0,0,        0,0,            0,'h20,1,     0,0,0,            0,0,0);
      // M1 access the ROM never grants: ERR on the 4th BUSY cycle
      tv[25] = v(0, 0,0,0,        1,'h80,2,     0,0,            0,'h20,1,     0,0,0,            0,0,0);
      tv[26] = v(0, 0,0,0,        1,'h80,2,     0,0,            1,'h80,2,     0,0,0,            0,0,0);
      tv[27] = v(0, 0,0,0,        1,'h80,2,     0,0,            1,'h80,2,     0,0,0,            0,0,0);
      tv[28] = v(0, 0,0,0,        1,'h80,2,     0,0,            1,'h80,2,     0,0,0,            0,0,0);
      tv[29] = v(0, 0,0,0,        1,'h80,2,     0,0,            1,'h80,2,     0,0,0,            0,1,0);
      tv[30] = v(0, 0,0,0,        0,0,0,        0,0,            0,'h80,2,     0,0,0,            0,0,0);
      // grant arrives on the last watchdog cycle: GNT only
      tv[31] = v(0, 1,'h84,0,     0,0,0,        0,0,            0,'h80,2,     0,0,0,            0,0,0);
      tv[32] = v(0, 1,'h84,0,     0,0,0,        0,0,            1,'h84,0,     0,0,0,            0,0,0);
      tv[33] = v(0, 1,'h84,0,     0,0,0,        0,0,            1,'h84,0,     0,0,0,            0,0,0);
      tv[34] = v(0, 1,'h84,0,     0,0,0,        0,0,            1,'h84,0,     0,0,0,            0,0,0);
      tv[35] = v(0, 1,'h84,0,     0,0,0,        1,'hFFFFFF80,   1,'h84,0,     1,0,'hFFFFFF80,   0,0,0);
      tv[36] = v(0, 0,0,0,        0,0,0,        0,0,            0,'h84,0,     0,0,0,            0,0,0);
      // stray ROM grant while idle
      tv[37] = v(0, 0,0,0,        0,0,0,        1,'h12345678,   0,'h84,0,     0,0,0,            0,0,0);
      tv[38] = v(0, 0,0,0,        0,0,0,        1,'h12345678,   0,'h84,0,     0,0,0,            0,0,0);

      // reset held from time zero: every output low
      z = v(1, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 0,0,0);
      drive(z);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_all(-1, z);

      for (int i = 0; i < NV; i++) begin
         @(posedge clk);
         #1;
         drive(tv[i]);
         @(negedge clk);
         chk_all(i, tv[i]);
      end

      // reset in the middle of a BUSY cycle drops the access
      @(posedge clk); #1;
      bus.i_ROM_GNT = 1'b0; bus.i_ROM_RDATA = 32'h0;
      bus.i_M1_REQ = 1'b1; bus.i_M1_ADDR = 32'h100; bus.i_M1_HB = 2'b01;
      @(negedge clk);
      chk("rst_seq_idle_ce", 0, 32'(bus.o_ROM_CE), 32'd0);
      @(posedge clk); #1;
      chk("rst_seq_busy_req", 1, 32'(bus.o_ROM_REQ), 32'd1);
      chk("rst_seq_busy_addr", 1, bus.o_ROM_ADDR, 32'h100);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async_ce", 2, 32'(bus.o_ROM_CE), 32'd0);
      chk("rst_async_req", 2, 32'(bus.o_ROM_REQ), 32'd0);
      chk("rst_async_addr", 2, bus.o_ROM_ADDR, 32'h0);
      chk("rst_async_hb", 2, 32'(bus.o_ROM_HB), 32'd0);
      bus.i_ROM_GNT = 1'b1; bus.i_ROM_RDATA = 32'hCAFEF00D;
      @(negedge clk);
      chk("rst_drop_gnt", 3, 32'(bus.o_M1_GNT), 32'd0);
      chk("rst_drop_rdata", 3, bus.o_M1_RDATA, 32'h0);
      chk("rst_drop_err", 3, 32'(bus.o_M1_ERR), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      bus.i_ROM_GNT = 1'b0; bus.i_ROM_RDATA = 32'h0;
      @(negedge clk);
      chk("rel_idle_ce", 4, 32'(bus.o_ROM_CE), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rel_busy_req", 5, 32'(bus.o_ROM_REQ), 32'd1);
      chk("rel_busy_addr", 5, bus.o_ROM_ADDR, 32'h100);
      chk("rel_busy_hb", 5, 32'(bus.o_ROM_HB), 32'd1);
      @(posedge clk); #1;
      bus.i_ROM_GNT = 1'b1; bus.i_ROM_RDATA = 32'hCAFEF00D;
      @(negedge clk);
      chk("rel_m1_gnt", 6, 32'(bus.o_M1_GNT), 32'd1);
      chk("rel_m1_rdata", 6, bus.o_M1_RDATA, 32'hCAFEF00D);
      chk("rel_m1_err", 6, 32'(bus.o_M1_ERR), 32'd0);
      chk("rel_m0_gnt", 6, 32'(bus.o_M0_GNT), 32'd0);
      @(posedge clk); #1;
      bus.i_M1_REQ = 1'b0;
      bus.i_ROM_GNT = 1'b0; bus.i_ROM_RDATA = 32'h0;
      @(negedge clk);
      chk("rel_done_ce", 7, 32'(bus.o_ROM_CE), 32'd0);
      chk("rel_done_gnt", 7, 32'(bus.o_M1_GNT), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
